dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (dmem) between two requesters: requester 0 is the processor data port and requester 1 is a secondary master (debug loader / DMA). It arbitrates per access using round-robin or fixed priority. It drives the dmem address, data and write-enable, holds the address through the synchronous read latency, and returns read data with a valid pulse. It sits between the processor's dmem outputs and the dmem instance in the top-level wrapper.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
RD_LAT, 1, cycles from the grant cycle to valid q_dmem; legal range 1..4
FIXED_PRI, 0, 0 = round-robin; 1 = requester 0 always wins ties

Ports:
clock  in  1  master clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
req0 / req1  in  1  access request; held with its address/we/wdata until gntN is seen
we0 / we1  in  1  1 = write, 0 = read
addr0 / addr1  in  ADDR_W  word address
wdata0 / wdata1  in  DATA_W  write data
gnt0 / gnt1  out  1  access accepted this cycle (combinational from req and state)
rvalid0 / rvalid1  out  1  one-cycle pulse; rdataN valid
rdata0 / rdata1  out  DATA_W  read data; registered copy, held until the next rvalid for that port
stall0  out  1  req0 & ~gnt0; fed to the processor's pipeline stall
address_dmem  out  ADDR_W  to dmem
data  out  DATA_W  to dmem
wren  out  1  to dmem
q_dmem  in  DATA_W  from dmem

Behaviour:
- Reset (while reset=1 and on the cycle after): state=IDLE; gnt0=gnt1=0; rvalid0=rvalid1=0; wren=0; address_dmem=0; data=0; rdata0=rdata1=0; last-served pointer=1, so requester 0 wins the first tie.
- States:
  - IDLE: arbitrate.
  - RD_WAIT: a read is in flight; a down-counter is loaded with RD_LAT.
- IDLE, single request: grant it in the same cycle.
- IDLE, both requesting:
  - FIXED_PRI=1: requester 0 wins.
  - FIXED_PRI=0: the requester not equal to last-served wins.
  - The pointer updates to the winner at the clock edge.
- Grant cycle, memory side: address_dmem = winner's address; data = winner's wdata; wren = winner's we. With no grant: wren=0, and address/data hold their last values.
- Write: completes in the grant cycle. State stays IDLE, so back-to-back writes (including alternating requesters) are granted every cycle.
- Read: at the grant edge, register the address, the requester id and counter=RD_LAT, then go to RD_WAIT.
  - In RD_WAIT: address_dmem holds the registered address; wren=0; no grants, so both gnt are 0 and stall0 follows req0.
  - Counter decrements each cycle. On the edge where counter==1, capture q_dmem into the owner's rdata and pulse its rvalid for the next cycle. State returns to IDLE on the same edge.
  - Timing: a read granted in cycle T gives rvalidN in cycle T+RD_LAT+1. A new grant is possible in that same rvalid cycle, so a read occupies RD_LAT+1 cycles of the port.
- A requester dropping req in the grant cycle has no effect; the access is already issued. Dropping req while waiting for a grant withdraws it without penalty.
- gnt0 and gnt1 are never both 1. rvalid0 and rvalid1 are never both 1.
- Reset during RD_WAIT: the read is aborted, no rvalid is produced, state=IDLE, and all outputs take their reset values.
- Address is word-granular and unchanged by the arbiter; no wrap or translation.
- No registered timing from req to gnt: the grant is combinational so that the processor's stall resolves in the same cycle.

Test Plan:
- Reset: hold reset 2 cycles with req0=req1=1 -> gnt0=gnt1=0, wren=0, address_dmem=0. First cycle after release -> gnt0=1 (pointer=1).
- Single write: req0=1, we0=1, addr0=12'h010, wdata0=32'hDEADBEEF -> same cycle gnt0=1, wren=1, address_dmem=12'h010, data=32'hDEADBEEF. Next cycle wren=0.
- Read latency (RD_LAT=1): req1 read at addr 12'h010, granted cycle T -> rvalid1=1 at T+2 with rdata1=32'hDEADBEEF. stall0=1 for T+1 if req0 is asserted.
- Round-robin: req0 and req1 both issue continuous writes for 4 cycles -> grants alternate 0,1,0,1. With FIXED_PRI=1 -> gnt0 in all 4 cycles and gnt1 never asserts.
- Mixed contention: req0 read at 12'h020 and req1 write at 12'h020 (32'h1234) arrive simultaneously, pointer=1 -> read granted first and returns the old contents at T+2. Write granted at T+2. A re-read returns 32'h1234.
- Reset mid-read: assert reset in the RD_WAIT cycle -> no rvalid0/rvalid1 ever pulses for that read; next request is granted normally after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the processor (port 0) and a secondary master (port 1).
// Writes take one cycle and can issue back-to-back. A read holds the port for RD_LAT+1 cycles. A requester that loses holds req and sees gnt=0.
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall0,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CNT_W = 3;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q;
  logic               owner_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               sel;
  logic               sel_we;
  logic               gnt_any;
  logic               rd_done;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  assign rd_done = (state_q == RD_WAIT) && (cnt_q == CNT_W'(1));

  always_comb begin
    sel     = 1'b0;
    gnt_any = 1'b0;
    state_d = state_q;
    if (!reset && state_q == IDLE && (req0 || req1)) begin
      gnt_any = 1'b1;
      // On a tie the requester that was not served last wins, unless port 0 has fixed priority.
      if (req0 && req1) sel = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
      else              sel = req1;
    end
    sel_addr = sel ? addr1  : addr0;
    sel_data = sel ? wdata1 : wdata0;
    sel_we   = sel ? we1    : we0;
    gnt0     = gnt_any & ~sel;
    gnt1     = gnt_any & sel;
    stall0   = req0 & ~gnt0;
    wren     = gnt_any & sel_we;
    if (reset) begin
      address_dmem = '0;
      data         = '0;
    end else if (gnt_any) begin
      address_dmem = sel_addr;
      data         = sel_data;
    end else begin
      address_dmem = addr_q;
      data         = data_q;
    end
    if (gnt_any && !sel_we) state_d = RD_WAIT;
    else if (rd_done)       state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (gnt_any) begin
        last_q <= sel;
        addr_q <= sel_addr;
        data_q <= sel_data;
        if (!sel_we) begin
          owner_q <= sel;
          cnt_q   <= CNT_W'(RD_LAT);
        end
      end else if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
        if (rd_done) begin
          if (owner_q) begin
            rdata1  <= q_dmem;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= q_dmem;
            rvalid0 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a memory model, and a fixed-priority instance.
// Expected grants and read data are queued up front and checked against the DUT by a monitor on the falling edge.
module tb_dmem_arbiter;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  typedef struct {
    logic          p;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } g_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          req_s  [2][2];
  logic          we_s   [2][2];
  logic [AW-1:0] addr_s [2][2];
  logic [DW-1:0] wd_s   [2][2];

  logic gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, stall0_a, wren_a;
  logic [DW-1:0] rdata0_a, rdata1_a, dat_a, q_dmem;
  logic [AW-1:0] adm_a;
  logic gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, stall0_f, wren_f;
  logic [DW-1:0] rdata0_f, rdata1_f, dat_f;
  logic [AW-1:0] adm_f;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  g_t   eg0[$];
  g_t   eg1[$];
  logic [DW-1:0] erd0[$];
  logic [DW-1:0] erd1[$];
  int   rvq0[$];
  int   rvq1[$];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .FIXED_PRI(0)) u_rr (
    .clock(clock), .reset(reset),
    .req0(req_s[0][0]), .req1(req_s[0][1]), .we0(we_s[0][0]), .we1(we_s[0][1]),
    .addr0(addr_s[0][0]), .addr1(addr_s[0][1]), .wdata0(wd_s[0][0]), .wdata1(wd_s[0][1]),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
    .rdata0(rdata0_a), .rdata1(rdata1_a), .stall0(stall0_a),
    .address_dmem(adm_a), .data(dat_a), .wren(wren_a), .q_dmem(q_dmem));

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .FIXED_PRI(1)) u_fix (
    .clock(clock), .reset(reset),
    .req0(req_s[1][0]), .req1(req_s[1][1]), .we0(we_s[1][0]), .we1(we_s[1][1]),
    .addr0(addr_s[1][0]), .addr1(addr_s[1][1]), .wdata0(wd_s[1][0]), .wdata1(wd_s[1][1]),
    .gnt0(gnt0_f), .gnt1(gnt1_f), .rvalid0(rvalid0_f), .rvalid1(rvalid1_f),
    .rdata0(rdata0_f), .rdata1(rdata1_f), .stall0(stall0_f),
    .address_dmem(adm_f), .data(dat_f), .wren(wren_f), .q_dmem(32'h0));

  // Synchronous single-port memory: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (wren_a) mem[adm_a] <= dat_a;
    q_dmem <= mem[adm_a];
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic g_t mk(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    g_t g;
    g.p = p; g.we = we; g.a = a; g.d = d;
    return g;
  endfunction

  function automatic logic get_gnt(input int i, input int p);
    if (i == 0) return (p == 0) ? gnt0_a : gnt1_a;
    return (p == 0) ? gnt0_f : gnt1_f;
  endfunction

  task automatic issue(input int i, input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int gc);
    int n = 0;
    req_s[i][p] = 1'b1; we_s[i][p] = w; addr_s[i][p] = a; wd_s[i][p] = d;
    gc = -1;
    while (gc < 0 && n < 50) begin
      @(negedge clock);
      if (get_gnt(i, p)) gc = cyc;
      n++;
    end
    if (gc < 0) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    req_s[i][p] = 1'b0;
  endtask

  // Monitor for the round-robin instance.
  initial forever begin
    g_t e;
    @(negedge clock);
    if (reset) begin
      rvq0.delete();
      rvq1.delete();
    end
    if (gnt0_a || gnt1_a) begin
      chk("gnt_onehot", {31'd0, gnt0_a & gnt1_a}, 32'd0);
      if (eg0.size() == 0) chk("unexpected_grant", {30'd0, gnt1_a, gnt0_a}, 32'd0);
      else begin
        e = eg0.pop_front();
        chk("gnt_port", {31'd0, gnt1_a}, {31'd0, e.p});
        chk("gnt_wren", {31'd0, wren_a}, {31'd0, e.we});
        chk("gnt_addr", {20'd0, adm_a}, {20'd0, e.a});
        if (e.we) chk("gnt_data", dat_a, e.d);
        else if (e.p) rvq1.push_back(cyc + RD_LAT + 1);
        else          rvq0.push_back(cyc + RD_LAT + 1);
      end
    end
    if (rvalid0_a || rvalid1_a) chk("rvalid_onehot", {31'd0, rvalid0_a & rvalid1_a}, 32'd0);
    if (rvalid0_a) begin
      if (erd0.size() == 0) chk("unexpected_rvalid0", {31'd0, rvalid0_a}, 32'd0);
      else chk("rdata0", rdata0_a, erd0.pop_front());
      if (rvq0.size() != 0) chk("rvalid0_cycle", cyc, rvq0.pop_front());
    end
    if (rvalid1_a) begin
      if (erd1.size() == 0) chk("unexpected_rvalid1", {31'd0, rvalid1_a}, 32'd0);
      else chk("rdata1", rdata1_a, erd1.pop_front());
      if (rvq1.size() != 0) chk("rvalid1_cycle", cyc, rvq1.pop_front());
    end
  end

  // Monitor for the fixed-priority instance (writes only).
  initial forever begin
    g_t e;
    @(negedge clock);
    if (gnt0_f || gnt1_f) begin
      if (eg1.size() == 0) chk("fix_unexpected_grant", {30'd0, gnt1_f, gnt0_f}, 32'd0);
      else begin
        e = eg1.pop_front();
        chk("fix_gnt_port", {31'd0, gnt1_f}, {31'd0, e.p});
        chk("fix_gnt_addr", {20'd0, adm_f}, {20'd0, e.a});
        chk("fix_gnt_data", dat_f, e.d);
        chk("fix_gnt_wren", {31'd0, wren_f}, 32'd1);
        if (gnt0_f) chk("fix_stall0", {31'd0, stall0_f}, 32'd0);
      end
    end
    if (rvalid0_f || rvalid1_f) chk("fix_unexpected_rvalid", rdata0_f | rdata1_f | 32'd1, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, g1, g2, g3, rel;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req_s[i][p] = 1'b0; we_s[i][p] = 1'b0; addr_s[i][p] = '0; wd_s[i][p] = '0;
      end

    // Reset with both requesting; port 0 wins first after release.
    reset = 1'b1;
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 12'h020; wd_s[0][0] = 32'h0BAD0000;
    req_s[0][1] = 1'b1; we_s[0][1] = 1'b1; addr_s[0][1] = 12'h006; wd_s[0][1] = 32'h00000066;
    @(posedge clock);
    @(negedge clock);
    chk("rst_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd0);
    chk("rst_wren", {31'd0, wren_a}, 32'd0);
    chk("rst_addr", {20'd0, adm_a}, 32'd0);
    chk("rst_data", dat_a, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1_a, rvalid0_a}, 32'd0);
    chk("rst_rdata", rdata0_a | rdata1_a, 32'd0);
    chk("rst_stall0", {31'd0, stall0_a}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    rel = cyc;
    eg0.push_back(mk(1'b0, 1'b1, 12'h020, 32'h0BAD0000));
    eg0.push_back(mk(1'b1, 1'b1, 12'h006, 32'h00000066));
    fork
      issue(0, 0, 1'b1, 12'h020, 32'h0BAD0000, g0);
      issue(0, 1, 1'b1, 12'h006, 32'h00000066, g1);
    join
    chk("rst_first_gnt_cycle", g0, rel);
    chk("rst_second_gnt_cycle", g1, rel + 1);

    // Single write, then wren drops.
    eg0.push_back(mk(1'b0, 1'b1, 12'h010, 32'hDEADBEEF));
    issue(0, 0, 1'b1, 12'h010, 32'hDEADBEEF, g0);
    @(negedge clock);
    chk("wr_wren_after", {31'd0, wren_a}, 32'd0);
    @(posedge clock); #1;

    // Read latency on port 1, port 0 stalls while the read is in flight.
    eg0.push_back(mk(1'b1, 1'b0, 12'h010, 32'h0));
    erd1.push_back(32'hDEADBEEF);
    issue(0, 1, 1'b0, 12'h010, 32'h0, g0);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 12'h030; wd_s[0][0] = 32'h30;
    @(negedge clock);
    chk("rdwait_stall0", {31'd0, stall0_a}, 32'd1);
    chk("rdwait_gnt", {30'd0, gnt1_a, gnt0_a}, 32'd0);
    chk("rdwait_wren", {31'd0, wren_a}, 32'd0);
    chk("rdwait_addr", {20'd0, adm_a}, 32'h010);
    eg0.push_back(mk(1'b0, 1'b1, 12'h030, 32'h30));
    issue(0, 0, 1'b1, 12'h030, 32'h30, g1);
    chk("grant_in_rvalid_cycle", g1, g0 + 2);

    // Round robin: set pointer to 1 with a port-1 write, then alternate.
    eg0.push_back(mk(1'b1, 1'b1, 12'h040, 32'h40));
    issue(0, 1, 1'b1, 12'h040, 32'h40, g0);
    eg0.push_back(mk(1'b0, 1'b1, 12'h100, 32'hA0));
    eg0.push_back(mk(1'b1, 1'b1, 12'h200, 32'hB0));
    eg0.push_back(mk(1'b0, 1'b1, 12'h101, 32'hA1));
    eg0.push_back(mk(1'b1, 1'b1, 12'h201, 32'hB1));
    fork
      begin issue(0, 0, 1'b1, 12'h100, 32'hA0, g0); issue(0, 0, 1'b1, 12'h101, 32'hA1, g1); end
      begin issue(0, 1, 1'b1, 12'h200, 32'hB0, g2); issue(0, 1, 1'b1, 12'h201, 32'hB1, g3); end
    join
    chk("rr_back_to_back", g3, g0 + 3);

    // Fixed priority: port 0 takes all four contended cycles.
    eg1.push_back(mk(1'b0, 1'b1, 12'h100, 32'hC0));
    eg1.push_back(mk(1'b0, 1'b1, 12'h101, 32'hC1));
    eg1.push_back(mk(1'b0, 1'b1, 12'h102, 32'hC2));
    eg1.push_back(mk(1'b0, 1'b1, 12'h103, 32'hC3));
    eg1.push_back(mk(1'b1, 1'b1, 12'h200, 32'hD0));
    eg1.push_back(mk(1'b1, 1'b1, 12'h201, 32'hD1));
    fork
      begin
        issue(1, 0, 1'b1, 12'h100, 32'hC0, g0); issue(1, 0, 1'b1, 12'h101, 32'hC1, g1);
        issue(1, 0, 1'b1, 12'h102, 32'hC2, g1); issue(1, 0, 1'b1, 12'h103, 32'hC3, g1);
      end
      begin issue(1, 1, 1'b1, 12'h200, 32'hD0, g2); issue(1, 1, 1'b1, 12'h201, 32'hD1, g3); end
    join
    chk("fix_port1_waits", g2, g0 + 4);

    // Mixed contention: read wins, returns old data; write follows two cycles later.
    eg0.push_back(mk(1'b0, 1'b0, 12'h020, 32'h0));
    eg0.push_back(mk(1'b1, 1'b1, 12'h020, 32'h1234));
    erd0.push_back(32'h0BAD0000);
    fork
      issue(0, 0, 1'b0, 12'h020, 32'h0, g0);
      issue(0, 1, 1'b1, 12'h020, 32'h1234, g1);
    join
    chk("mixed_write_cycle", g1, g0 + 2);
    eg0.push_back(mk(1'b0, 1'b0, 12'h020, 32'h0));
    erd0.push_back(32'h1234);
    issue(0, 0, 1'b0, 12'h020, 32'h0, g0);
    repeat (3) @(posedge clock);
    #1;

    // Reset during RD_WAIT aborts the read.
    eg0.push_back(mk(1'b1, 1'b0, 12'h010, 32'h0));
    issue(0, 1, 1'b0, 12'h010, 32'h0, g0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_addr", {20'd0, adm_a}, 32'd0);
    chk("midrst_wren", {31'd0, wren_a}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_rvalid", {30'd0, rvalid1_a, rvalid0_a}, 32'd0);
      chk("abort_rdata1", rdata1_a, 32'd0);
    end
    @(posedge clock); #1;
    eg0.push_back(mk(1'b0, 1'b1, 12'h050, 32'h5));
    issue(0, 0, 1'b1, 12'h050, 32'h5, g0);
    eg0.push_back(mk(1'b1, 1'b0, 12'h050, 32'h0));
    erd1.push_back(32'h5);
    issue(0, 1, 1'b0, 12'h050, 32'h0, g0);

    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("leftover_grants", eg0.size() + eg1.size(), 32'd0);
    chk("leftover_reads", erd0.size() + erd1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
